// File: rtl/fft_sdf_twiddle_ctrl.sv
// Stage sequencer and twiddle generator for one radix-2 SDF FFT stage.
// Outputs are registered and always describe the sample the next in_valid will accept.
module fft_sdf_twiddle_ctrl #(
  parameter int    LOG2N   = 10,
  parameter int    N_STAGE = 1024,
  parameter int    DW      = 24,
  parameter int    FRAC    = 8,
  parameter string TW_FILE = "twiddle_cos_1024.hex"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic                 inverse,
  output logic [1:0]           state,
  output logic signed [DW-1:0] w_r,
  output logic signed [DW-1:0] w_i,
  output logic                 blk_last,
  output logic                 inv_active
);

  localparam int AW   = LOG2N - 1;
  localparam int HALF = N_STAGE / 2;
  localparam int QTR  = N_STAGE / 4;

  localparam logic [AW-1:0]        H_LAST = AW'(HALF - 1);
  localparam logic [AW-1:0]        Q_IDX  = AW'(QTR);
  localparam logic signed [DW-1:0] W_ONE  = DW'(2 ** FRAC);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PASS = 2'd1,
    ST_BFLY = 2'd2
  } phase_e;

  generate
    if (LOG2N < 2 || N_STAGE != (1 << LOG2N) || TW_FILE == "") begin : g_bad_param
      $error("fft_sdf_twiddle_ctrl: invalid LOG2N/N_STAGE/TW_FILE");
    end
  endgenerate

  // Quarter-wave table, built at elaboration with the formula that defines the TW_FILE image.
  function automatic logic signed [DW-1:0] cos_q(input int m);
    real x;
    x = $cos(2.0 * 3.14159265358979323846 * real'(m) / real'(N_STAGE)) * (2.0 ** FRAC);
    return DW'($rtoi(x + 0.5));
  endfunction

  logic signed [DW-1:0] rom [QTR+1];

  generate
    for (genvar gi = 0; gi <= QTR; gi++) begin : g_rom
      assign rom[gi] = cos_q(gi);
    end
  endgenerate

  logic [AW-1:0] h_reg, h_next;
  logic          ph_reg, ph_next;
  logic          primed_reg, primed_next;
  logic          inv_reg, inv_next;
  phase_e        state_reg;
  logic          bfly_next;
  logic [AW-1:0] addr_a, addr_b;
  logic          neg_a, neg_b;

  always_comb begin
    h_next      = h_reg;
    ph_next     = ph_reg;
    primed_next = primed_reg;
    inv_next    = inv_reg;
    if (clear) begin
      h_next      = '0;
      ph_next     = 1'b0;
      primed_next = 1'b0;
      inv_next    = 1'b0;
    end else if (in_valid) begin
      h_next = h_reg + 1'b1;
      if (h_reg == H_LAST) begin
        if (primed_reg) ph_next = ~ph_reg;
        else            primed_next = 1'b1;
      end
      if (primed_reg && !ph_reg && h_reg == '0)
        inv_next = inverse;
    end

    // Table addresses for the next sample; FILL/PASS read C[0] and C[N/4] (= 1.0, 0).
    bfly_next = primed_next & ph_next;
    addr_a    = '0;
    addr_b    = Q_IDX;
    neg_a     = 1'b0;
    neg_b     = 1'b0;
    if (bfly_next) begin
      neg_b = ~inv_next;
      if (h_next <= Q_IDX) begin
        addr_a = h_next;
        addr_b = Q_IDX - h_next;
      end else begin
        addr_a = Q_IDX - (h_next - Q_IDX);
        addr_b = h_next - Q_IDX;
        neg_a  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg      <= '0;
      ph_reg     <= 1'b0;
      primed_reg <= 1'b0;
      inv_reg    <= 1'b0;
      state_reg  <= ST_FILL;
      w_r        <= W_ONE;
      w_i        <= '0;
      blk_last   <= 1'b0;
    end else if (clear || in_valid) begin
      h_reg      <= h_next;
      ph_reg     <= ph_next;
      primed_reg <= primed_next;
      inv_reg    <= inv_next;
      if (!primed_next)  state_reg <= ST_FILL;
      else if (!ph_next) state_reg <= ST_PASS;
      else               state_reg <= ST_BFLY;
      w_r        <= neg_a ? -rom[addr_a] : rom[addr_a];
      w_i        <= neg_b ? -rom[addr_b] : rom[addr_b];
      blk_last   <= (h_next == H_LAST);
    end
  end

  assign state      = state_reg;
  assign inv_active = inv_reg;

endmodule
